// File: rtl/rx_stream_marker_pkg.sv
// rx_stream_marker_pkg
//   Shared constants for the RX stream marker: settings-bus addresses,
//   marker mode encodings, the fill pattern loaded at reset, and the
//   per-channel packet-framing state type.
package rx_stream_marker_pkg;

    localparam logic [7:0]  SR_MARKER_CTRL    = 8'd192;
    localparam logic [7:0]  SR_MARKER_PATTERN = 8'd193;
    localparam logic [31:0] DEFAULT_PATTERN   = 32'hABCD_BEEF;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,
        MODE_MARK_LAST = 2'd1,
        MODE_REPLACE   = 2'd2,
        MODE_RAMP      = 2'd3
    } marker_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } marker_state_e;

endpackage

// File: rtl/rx_stream_marker_chan.sv
// rx_stream_marker_chan
//   One channel of the RX stream marker: settings registers, packet
//   framing state machine, beat/packet counters and a single registered
//   AXI-stream output stage (latency 1, full throughput).
//
//   Handshake: a beat moves on an interface when tvalid & tready are both
//   high on a rising edge. i_tready = ~o_tvalid | o_tready, so the output
//   register is refilled in the same cycle it is emptied; while
//   o_tvalid & ~o_tready every o_* signal holds its value.
//
// Ports
//   clk, reset          ce_clk domain, synchronous active-high reset
//   clear               zero counters and framing state on the next edge
//   set_stb/addr/data   settings bus (mode register, fill pattern)
//   i_t*                input stream (tuser/tlast copied through)
//   o_t*                output stream
//   pkt_count           packets emitted on this channel (wraps)
module rx_stream_marker_chan #(
    parameter int          WIDTH             = 32,
    parameter int          USER_WIDTH        = 128,
    parameter logic [7:0]  SR_MARKER_CTRL    = rx_stream_marker_pkg::SR_MARKER_CTRL,
    parameter logic [7:0]  SR_MARKER_PATTERN = rx_stream_marker_pkg::SR_MARKER_PATTERN,
    parameter logic [31:0] DEFAULT_PATTERN   = rx_stream_marker_pkg::DEFAULT_PATTERN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [WIDTH-1:0]      i_tdata,
    input  logic [USER_WIDTH-1:0] i_tuser,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [WIDTH-1:0]      o_tdata,
    output logic [USER_WIDTH-1:0] o_tuser,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic [31:0]           pkt_count
);
    import rx_stream_marker_pkg::*;

    marker_mode_e  mode;
    marker_mode_e  active_mode;
    logic [31:0]   pattern;
    logic [31:0]   active_pattern;
    marker_state_e state;
    logic [15:0]   beat_idx;

    logic          accept;
    marker_mode_e  eff_mode;
    logic [31:0]   eff_pattern;
    logic [WIDTH-1:0] next_data;

    assign i_tready = ~o_tvalid | o_tready;
    assign accept   = i_tvalid & i_tready;

    // The first beat of a packet uses the live settings (they are latched
    // on that same edge); later beats use the values latched at packet start.
    always_comb begin
        eff_mode    = (state == ST_IDLE) ? mode    : active_mode;
        eff_pattern = (state == ST_IDLE) ? pattern : active_pattern;
        next_data   = '0;
        case (eff_mode)
            MODE_PASS:      next_data = i_tdata;
            MODE_MARK_LAST: begin
                if (i_tlast) next_data[31:0] = pkt_count;
                else         next_data       = i_tdata;
            end
            MODE_REPLACE:   next_data[31:0] = i_tlast ? pkt_count : eff_pattern;
            MODE_RAMP:      next_data[31:0] = {pkt_count[15:0], beat_idx};
            default:        next_data = i_tdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode           <= MODE_PASS;
            active_mode    <= MODE_PASS;
            pattern        <= DEFAULT_PATTERN;
            active_pattern <= DEFAULT_PATTERN;
            state          <= ST_IDLE;
            beat_idx       <= 16'd0;
            pkt_count      <= 32'd0;
            o_tvalid       <= 1'b0;
            o_tdata        <= '0;
            o_tuser        <= '0;
            o_tlast        <= 1'b0;
        end else begin
            if (set_stb) begin
                if (set_addr == SR_MARKER_CTRL)
                    mode <= marker_mode_e'(set_data[1:0]);
                else if (set_addr == SR_MARKER_PATTERN)
                    pattern <= set_data;
            end

            if (accept) begin
                o_tdata  <= next_data;
                o_tuser  <= i_tuser;
                o_tlast  <= i_tlast;
                o_tvalid <= 1'b1;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end

            if (accept && state == ST_IDLE) begin
                active_mode    <= mode;
                active_pattern <= pattern;
            end

            // Clear wins over a same-cycle tlast; the registered output beat
            // above is kept either way.
            if (clear) begin
                state     <= ST_IDLE;
                beat_idx  <= 16'd0;
                pkt_count <= 32'd0;
            end else if (accept) begin
                if (i_tlast) begin
                    state     <= ST_IDLE;
                    beat_idx  <= 16'd0;
                    pkt_count <= pkt_count + 32'd1;
                end else begin
                    state     <= ST_IN_PKT;
                    beat_idx  <= beat_idx + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/rx_stream_marker.sv
// rx_stream_marker
//   Multi-channel AXI-stream marker stage between the radio datapath RX
//   output and the NoC wrapper input. Each channel is an independent
//   rx_stream_marker_chan; this level only slices the flat buses.
//
// Ports (all buses are NUM_CHANNELS lanes concatenated, lane 0 in the LSBs)
//   clk, reset          ce_clk domain, synchronous active-high reset
//   clear               per-channel counter/state clear
//   set_stb/addr/data   per-channel settings bus (8-bit addr, 32-bit data)
//   i_t*                input streams
//   o_t*                output streams
//   pkt_count           32-bit packet counter per channel
module rx_stream_marker #(
    parameter int          NUM_CHANNELS      = 1,
    parameter int          WIDTH             = 32,
    parameter int          USER_WIDTH        = 128,
    parameter logic [7:0]  SR_MARKER_CTRL    = rx_stream_marker_pkg::SR_MARKER_CTRL,
    parameter logic [7:0]  SR_MARKER_PATTERN = rx_stream_marker_pkg::SR_MARKER_PATTERN,
    parameter logic [31:0] DEFAULT_PATTERN   = rx_stream_marker_pkg::DEFAULT_PATTERN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CHANNELS-1:0]          clear,
    input  logic [NUM_CHANNELS-1:0]          set_stb,
    input  logic [8*NUM_CHANNELS-1:0]        set_addr,
    input  logic [32*NUM_CHANNELS-1:0]       set_data,
    input  logic [WIDTH*NUM_CHANNELS-1:0]    i_tdata,
    input  logic [USER_WIDTH*NUM_CHANNELS-1:0] i_tuser,
    input  logic [NUM_CHANNELS-1:0]          i_tlast,
    input  logic [NUM_CHANNELS-1:0]          i_tvalid,
    output logic [NUM_CHANNELS-1:0]          i_tready,
    output logic [WIDTH*NUM_CHANNELS-1:0]    o_tdata,
    output logic [USER_WIDTH*NUM_CHANNELS-1:0] o_tuser,
    output logic [NUM_CHANNELS-1:0]          o_tlast,
    output logic [NUM_CHANNELS-1:0]          o_tvalid,
    input  logic [NUM_CHANNELS-1:0]          o_tready,
    output logic [32*NUM_CHANNELS-1:0]       pkt_count
);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        rx_stream_marker_chan #(
            .WIDTH             (WIDTH),
            .USER_WIDTH        (USER_WIDTH),
            .SR_MARKER_CTRL    (SR_MARKER_CTRL),
            .SR_MARKER_PATTERN (SR_MARKER_PATTERN),
            .DEFAULT_PATTERN   (DEFAULT_PATTERN)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear[i]),
            .set_stb   (set_stb[i]),
            .set_addr  (set_addr[8*i +: 8]),
            .set_data  (set_data[32*i +: 32]),
            .i_tdata   (i_tdata[WIDTH*i +: WIDTH]),
            .i_tuser   (i_tuser[USER_WIDTH*i +: USER_WIDTH]),
            .i_tlast   (i_tlast[i]),
            .i_tvalid  (i_tvalid[i]),
            .i_tready  (i_tready[i]),
            .o_tdata   (o_tdata[WIDTH*i +: WIDTH]),
            .o_tuser   (o_tuser[USER_WIDTH*i +: USER_WIDTH]),
            .o_tlast   (o_tlast[i]),
            .o_tvalid  (o_tvalid[i]),
            .o_tready  (o_tready[i]),
            .pkt_count (pkt_count[32*i +: 32])
        );
    end

endmodule

// File: tb/tb_rx_stream_marker.sv
// tb_rx_stream_marker
//   Two-channel bench. A packet-level model predicts every output beat and
//   the packet counters; a negedge monitor compares the DUT against it on
//   every cycle, and each directed scenario also checks literal values.
module tb_rx_stream_marker;
    localparam int NCH   = 2;
    localparam int W     = 32;
    localparam int UW    = 128;
    localparam int EXP_W = W + UW + 1;
    localparam logic [31:0] DEF_PAT = 32'hABCD_BEEF;

    logic clk = 1'b0;
    logic reset;
    logic [NCH-1:0]      clear, set_stb, i_tlast, i_tvalid, i_tready;
    logic [NCH-1:0]      o_tlast, o_tvalid, o_tready;
    logic [8*NCH-1:0]    set_addr;
    logic [32*NCH-1:0]   set_data, pkt_count;
    logic [W*NCH-1:0]    i_tdata, o_tdata;
    logic [UW*NCH-1:0]   i_tuser, o_tuser;

    always #5 clk = ~clk;

    rx_stream_marker #(
        .NUM_CHANNELS (NCH),
        .WIDTH        (W),
        .USER_WIDTH   (UW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .i_tdata   (i_tdata),
        .i_tuser   (i_tuser),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tuser   (o_tuser),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .pkt_count (pkt_count)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Expected output beats per channel: {data, user, last}.
    logic [EXP_W-1:0] exp_q [NCH][$];
    logic [31:0]      got_q [NCH][$];
    logic [1:0]  m_mode [NCH];
    logic [1:0]  m_amode[NCH];
    logic [31:0] m_pat  [NCH];
    logic [31:0] m_apat [NCH];
    logic [31:0] m_cnt  [NCH];
    logic [15:0] m_beat [NCH];
    bit          m_in_pkt[NCH];
    bit          chk_en = 1'b0;
    logic [EXP_W-1:0] head;
    bit          busy;
    bit          rdy;

    function automatic logic [W-1:0] marked_word(input logic [1:0] md, input logic [31:0] pat,
                                                 input logic [31:0] cnt, input logic [15:0] beat,
                                                 input logic last, input logic [W-1:0] din);
        case (md)
            2'd0:    return din;
            2'd1:    return last ? cnt : din;
            2'd2:    return last ? cnt : pat;
            default: return {cnt[15:0], beat};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            busy = (exp_q[c].size() > 0);
            if (chk_en) begin
                check($sformatf("ch%0d o_tvalid", c), o_tvalid[c], busy);
                check($sformatf("ch%0d i_tready", c), i_tready[c], !busy || o_tready[c]);
                check($sformatf("ch%0d pkt_count", c), pkt_count[32*c +: 32], m_cnt[c]);
                if (busy) begin
                    head = exp_q[c][0];
                    check($sformatf("ch%0d o_tdata", c), o_tdata[W*c +: W], head[EXP_W-1 -: W]);
                    check($sformatf("ch%0d o_tuser", c), o_tuser[UW*c +: UW], head[UW:1]);
                    check($sformatf("ch%0d o_tlast", c), o_tlast[c], head[0]);
                end
            end
            // advance the model across the coming rising edge
            if (reset) begin
                exp_q[c].delete();
                m_mode[c] = 2'd0; m_amode[c] = 2'd0;
                m_pat[c] = DEF_PAT; m_apat[c] = DEF_PAT;
                m_cnt[c] = 32'd0; m_beat[c] = 16'd0; m_in_pkt[c] = 1'b0;
            end else begin
                rdy = !busy || o_tready[c];
                if (busy && o_tready[c]) begin
                    got_q[c].push_back(o_tdata[W*c +: W]);
                    void'(exp_q[c].pop_front());
                end
                if (i_tvalid[c] && rdy) begin
                    if (!m_in_pkt[c]) begin
                        m_amode[c] = m_mode[c];
                        m_apat[c]  = m_pat[c];
                    end
                    exp_q[c].push_back({marked_word(m_amode[c], m_apat[c], m_cnt[c], m_beat[c],
                                                    i_tlast[c], i_tdata[W*c +: W]),
                                        i_tuser[UW*c +: UW], i_tlast[c]});
                    if (i_tlast[c]) begin
                        m_cnt[c] = m_cnt[c] + 32'd1; m_beat[c] = 16'd0; m_in_pkt[c] = 1'b0;
                    end else begin
                        m_beat[c] = m_beat[c] + 16'd1; m_in_pkt[c] = 1'b1;
                    end
                end
                if (clear[c]) begin
                    m_cnt[c] = 32'd0; m_beat[c] = 16'd0; m_in_pkt[c] = 1'b0;
                end
                if (set_stb[c]) begin
                    if (set_addr[8*c +: 8] == 8'd192)      m_mode[c] = set_data[32*c +: 2];
                    else if (set_addr[8*c +: 8] == 8'd193) m_pat[c]  = set_data[32*c +: 32];
                end
            end
        end
    end

    // ---------------- downstream ready generator ----------------
    // 0: always ready, 1: toggle every cycle, 2: never ready
    int rdy_mode[NCH];
    bit phase = 1'b0;
    initial begin
        o_tready = '1;
        forever begin
            @(posedge clk); #1;
            phase = ~phase;
            for (int c = 0; c < NCH; c++)
                o_tready[c] = (rdy_mode[c] == 0) ? 1'b1 : (rdy_mode[c] == 1) ? phase : 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int c, input logic [31:0] d, input logic last);
        int n;
        bit acc;
        i_tdata[W*c +: W]   = d;
        i_tuser[UW*c +: UW] = {4{d ^ 32'h1111_1111}};
        i_tlast[c]  = last;
        i_tvalid[c] = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk); acc = i_tready[c];
            @(posedge clk); #1; n++;
        end
        check($sformatf("ch%0d input accepted", c), acc, 1'b1);
        i_tvalid[c] = 1'b0;
        i_tlast[c]  = 1'b0;
    endtask

    task automatic send_pkt(input int c, input logic [31:0] base, input int len);
        for (int b = 0; b < len; b++) send_beat(c, base + 32'(b), b == len - 1);
    endtask

    task automatic set_reg(input int c, input logic [7:0] addr, input logic [31:0] data);
        set_stb[c] = 1'b1;
        set_addr[8*c +: 8]   = addr;
        set_data[32*c +: 32] = data;
        @(posedge clk); #1;
        set_stb[c] = 1'b0;
    endtask

    task automatic pulse_clear(input int c);
        clear[c] = 1'b1;
        @(posedge clk); #1;
        clear[c] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("drain", (exp_q[0].size() == 0 && exp_q[1].size() == 0), 1'b1);
        @(posedge clk); #1;
    endtask

    logic [31:0] want[$];
    task automatic expect_seq(input string name, input int c);
        check({name, " count"}, got_q[c].size(), want.size());
        for (int i = 0; i < want.size() && i < got_q[c].size(); i++)
            check($sformatf("%s[%0d]", name, i), got_q[c][i], want[i]);
        got_q[c].delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; clear = '0; set_stb = '0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tuser = '0; i_tlast = '0; i_tvalid = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset o_tvalid", o_tvalid, 2'b00);
        check("reset o_tdata", o_tdata, 64'd0);
        check("reset o_tuser", o_tuser, 256'd0);
        check("reset o_tlast", o_tlast, 2'b00);
        check("reset pkt_count", pkt_count, 64'd0);
        check("reset i_tready", i_tready, 2'b11);
        chk_en = 1'b1;

        // passthrough, three 4-beat packets on ch0, one on ch1
        for (int p = 0; p < 3; p++) send_pkt(0, 32'h1000 + 32'(16 * p), 4);
        send_pkt(1, 32'h7000, 2);
        drain();
        want = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1010, 32'h1011, 32'h1012, 32'h1013,
                 32'h1020, 32'h1021, 32'h1022, 32'h1023};
        expect_seq("pass ch0", 0);
        want = '{32'h7000, 32'h7001};
        expect_seq("pass ch1", 1);
        check("pass pkt_count ch0", pkt_count[31:0], 32'd3);
        check("pass pkt_count ch1", pkt_count[63:32], 32'd1);

        // replace mode, pattern rewritten in the middle of the second packet
        set_reg(0, 8'd192, 32'd2);
        pulse_clear(0);
        send_pkt(0, 32'h100, 4);
        send_beat(0, 32'h200, 1'b0);
        send_beat(0, 32'h201, 1'b0);
        set_reg(0, 8'd193, 32'h1234_5678);
        send_beat(0, 32'h202, 1'b0);
        send_beat(0, 32'h203, 1'b1);
        send_pkt(0, 32'h300, 4);
        drain();
        want = '{DEF_PAT, DEF_PAT, DEF_PAT, 32'd0, DEF_PAT, DEF_PAT, DEF_PAT, 32'd1,
                 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'd2};
        expect_seq("replace", 0);

        // ramp mode with downstream backpressure every other cycle
        set_reg(0, 8'd192, 32'd3);
        pulse_clear(0);
        rdy_mode[0] = 1;
        for (int p = 0; p < 3; p++) send_pkt(0, 32'h55 + 32'(p), 3);
        drain();
        rdy_mode[0] = 0;
        want = '{32'h0, 32'h1, 32'h2, 32'h1_0000, 32'h1_0001, 32'h1_0002,
                 32'h2_0000, 32'h2_0001, 32'h2_0002};
        expect_seq("ramp", 0);

        // mark-last across the packet counter wrap
        set_reg(0, 8'd192, 32'd1);
        drain();
        force dut.g_chan[0].u_chan.pkt_count = 32'hFFFF_FFFF;
        m_cnt[0] = 32'hFFFF_FFFF;
        #1 release dut.g_chan[0].u_chan.pkt_count;
        send_pkt(0, 32'hA0, 3);
        send_pkt(0, 32'hB0, 1);
        send_pkt(0, 32'hC0, 1);
        drain();
        want = '{32'hA0, 32'hA1, 32'hFFFF_FFFF, 32'd0, 32'd1};
        expect_seq("mark wrap", 0);
        check("mark pkt_count", pkt_count[31:0], 32'd2);

        // clear coinciding with an accepted tlast; ch1 isolation
        send_beat(0, 32'hD0, 1'b0);
        clear[0] = 1'b1;
        send_beat(0, 32'hD1, 1'b1);
        clear[0] = 1'b0;
        check("clear pkt_count ch0", pkt_count[31:0], 32'd0);
        set_reg(0, 8'd192, 32'd2);
        set_reg(0, 8'd193, 32'hCAFE_0000);
        check("isolation pkt_count ch1", pkt_count[63:32], 32'd1);
        send_pkt(1, 32'h7100, 2);
        drain();
        want = '{32'hD0, 32'd2};
        expect_seq("clear ch0", 0);
        want = '{32'h7100, 32'h7101};
        expect_seq("isolation ch1", 1);
        check("isolation pkt_count ch1 after", pkt_count[63:32], 32'd2);

        // reset while a beat is stalled in the output register
        rdy_mode[0] = 2;
        @(posedge clk); #1;
        send_beat(0, 32'hE0, 1'b0);
        @(posedge clk); #1;
        check("stalled o_tvalid", o_tvalid[0], 1'b1);
        check("stalled o_tdata", o_tdata[31:0], 32'hCAFE_0000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_mode[0] = 0;
        check("post-reset o_tvalid", o_tvalid, 2'b00);
        check("post-reset o_tdata", o_tdata[31:0], 32'd0);
        check("post-reset pkt_count", pkt_count, 64'd0);
        got_q[0].delete();
        send_pkt(0, 32'hF0, 2);
        set_reg(0, 8'd192, 32'd2);
        send_pkt(0, 32'hF8, 3);
        drain();
        want = '{32'hF0, 32'hF1, DEF_PAT, DEF_PAT, 32'd1};
        expect_seq("post-reset", 0);
        check("post-reset pkt_count final", pkt_count[31:0], 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
